// File: rtl/lcd_bus_rx.sv
`timescale 1ns/1ps
// lcd_bus_rx: receive end of the 8-bit write-only LCD bus. It oversamples wr/dc/data,
// decodes CASET/RASET/RAMWR/SWRESET and emits addressed RGB565 pixel writes.
module lcd_bus_rx #(
  parameter int H_RES = 48,
  parameter int V_RES = 640,
  parameter int X_W   = 6,
  parameter int Y_W   = 10
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [7:0]     i_lcd_data,
  input  logic           i_lcd_wr,
  input  logic           i_lcd_dc,
  input  logic           i_lcd_rst,
  output logic           o_cmd_valid,
  output logic [7:0]     o_cmd,
  output logic           o_px_valid,
  output logic [15:0]    o_px_data,
  output logic [X_W-1:0] o_px_x,
  output logic [Y_W-1:0] o_px_y,
  output logic           o_err
);

  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);
  localparam logic [15:0]    H_LIM = 16'(H_RES);
  localparam logic [15:0]    V_LIM = 16'(V_RES);

  typedef enum logic [2:0] {IDLE, CASET, RASET, RAMWR, SKIP} state_t;

  logic       wr_s1, wr_s2, wr_s3, dc_s1, dc_s2, prst_s1, prst_s2;
  logic [7:0] data_s1, data_s2;
  logic [1:0] fill;
  logic       strobe, soft_rst;

  // fill gates the strobe until wr_s2/wr_s3 both hold post-reset pin samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_s1   <= 1'b0;
      wr_s2   <= 1'b0;
      wr_s3   <= 1'b0;
      dc_s1   <= 1'b0;
      dc_s2   <= 1'b0;
      data_s1 <= 8'h00;
      data_s2 <= 8'h00;
      prst_s1 <= 1'b1;
      prst_s2 <= 1'b1;
      fill    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes these chains behave as shift registers.
      wr_s1   <= i_lcd_wr;
      wr_s2   <= wr_s1;
      wr_s3   <= wr_s2;
      dc_s1   <= i_lcd_dc;
      dc_s2   <= dc_s1;
      data_s1 <= i_lcd_data;
      data_s2 <= data_s1;
      prst_s1 <= i_lcd_rst;
      prst_s2 <= prst_s1;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  assign strobe   = (fill == 2'd3) && wr_s2 && !wr_s3;
  assign soft_rst = i_rst || !prst_s2;

  logic       cap_stb, cap_dc;
  logic [7:0] cap_byte;

  always_ff @(posedge i_clk) begin
    if (soft_rst) begin
      cap_stb  <= 1'b0;
      cap_dc   <= 1'b0;
      cap_byte <= 8'h00;
    end else begin
      cap_stb <= strobe;
      if (strobe) begin
        cap_dc   <= dc_s2;
        cap_byte <= data_s2;
      end
    end
  end

  state_t         state, state_n;
  logic [1:0]     pcnt, pcnt_n;
  logic [7:0]     par0, par1, par2, par0_n, par1_n, par2_n;
  logic [X_W-1:0] xs, xe, x, xs_n, xe_n, x_n;
  logic [Y_W-1:0] ys, ye, y, ys_n, ye_n, y_n;
  logic           lo, lo_n;
  logic [7:0]     hi, hi_n;
  logic           cmd_valid_n, px_valid_n, err_n;
  logic [7:0]     cmd_n;
  logic [15:0]    px_data_n;
  logic [X_W-1:0] px_x_n;
  logic [Y_W-1:0] px_y_n;
  logic [15:0]    s_val, e_val;

  assign s_val = {par0, par1};
  assign e_val = {par2, cap_byte};

  always_ff @(posedge i_clk) begin
    if (soft_rst) begin
      state       <= IDLE;
      pcnt        <= 2'd0;
      par0        <= 8'h00;
      par1        <= 8'h00;
      par2        <= 8'h00;
      xs          <= '0;
      xe          <= X_MAX;
      ys          <= '0;
      ye          <= Y_MAX;
      x           <= '0;
      y           <= '0;
      lo          <= 1'b0;
      hi          <= 8'h00;
      o_cmd_valid <= 1'b0;
      o_cmd       <= 8'h00;
      o_px_valid  <= 1'b0;
      o_px_data   <= 16'h0000;
      o_px_x      <= '0;
      o_px_y      <= '0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_n;
      pcnt        <= pcnt_n;
      par0        <= par0_n;
      par1        <= par1_n;
      par2        <= par2_n;
      xs          <= xs_n;
      xe          <= xe_n;
      ys          <= ys_n;
      ye          <= ye_n;
      x           <= x_n;
      y           <= y_n;
      lo          <= lo_n;
      hi          <= hi_n;
      o_cmd_valid <= cmd_valid_n;
      o_cmd       <= cmd_n;
      o_px_valid  <= px_valid_n;
      o_px_data   <= px_data_n;
      o_px_x      <= px_x_n;
      o_px_y      <= px_y_n;
      o_err       <= err_n;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves one
    // unassigned would infer a latch.
    state_n     = state;
    pcnt_n      = pcnt;
    par0_n      = par0;
    par1_n      = par1;
    par2_n      = par2;
    xs_n        = xs;
    xe_n        = xe;
    ys_n        = ys;
    ye_n        = ye;
    x_n         = x;
    y_n         = y;
    lo_n        = lo;
    hi_n        = hi;
    cmd_valid_n = 1'b0;
    cmd_n       = o_cmd;
    px_valid_n  = 1'b0;
    px_data_n   = o_px_data;
    px_x_n      = o_px_x;
    px_y_n      = o_px_y;
    err_n       = 1'b0;

    if (cap_stb) begin
      if (!cap_dc) begin
        // A command aborts whatever was in progress, including a pending hi byte.
        cmd_valid_n = 1'b1;
        cmd_n       = cap_byte;
        pcnt_n      = 2'd0;
        lo_n        = 1'b0;
        case (cap_byte)
          8'h2A: state_n = CASET;
          8'h2B: state_n = RASET;
          8'h2C: begin
            state_n = RAMWR;
            x_n     = xs;
            y_n     = ys;
          end
          8'h01: begin
            state_n = IDLE;
            xs_n    = '0;
            xe_n    = X_MAX;
            ys_n    = '0;
            ye_n    = Y_MAX;
          end
          default: state_n = SKIP;
        endcase
      end else begin
        case (state)
          CASET, RASET: begin
            if (pcnt != 2'd3) begin
              case (pcnt)
                2'd0:    par0_n = cap_byte;
                2'd1:    par1_n = cap_byte;
                default: par2_n = cap_byte;
              endcase
              pcnt_n = pcnt + 2'd1;
            end else begin
              state_n = SKIP;
              pcnt_n  = 2'd0;
              if (state == CASET) begin
                if (s_val <= e_val && e_val < H_LIM) begin
                  xs_n = s_val[X_W-1:0];
                  xe_n = e_val[X_W-1:0];
                end else begin
                  err_n = 1'b1;
                end
              end else begin
                if (s_val <= e_val && e_val < V_LIM) begin
                  ys_n = s_val[Y_W-1:0];
                  ye_n = e_val[Y_W-1:0];
                end else begin
                  err_n = 1'b1;
                end
              end
            end
          end
          RAMWR: begin
            if (!lo) begin
              hi_n = cap_byte;
              lo_n = 1'b1;
            end else begin
              lo_n       = 1'b0;
              px_valid_n = 1'b1;
              px_data_n  = {hi, cap_byte};
              px_x_n     = x;
              px_y_n     = y;
              if (x == xe) begin
                x_n = xs;
                y_n = (y == ye) ? ys : y + 1'b1;
              end else begin
                x_n = x + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_rx.sv
`timescale 1ns/1ps
// Self-checking bench for lcd_bus_rx: table-driven byte vectors, hand-written corner
// sequences, and a randomized stream compared against an index-based window model.
module tb_lcd_bus_rx;

  logic        clk, rst;
  logic [7:0]  lcd_data;
  logic        lcd_wr, lcd_dc, lcd_rst;
  logic        cmd_valid, px_valid, err;
  logic [7:0]  cmd;
  logic [15:0] px_data;
  logic [5:0]  px_x;
  logic [9:0]  px_y;

  lcd_bus_rx #(.H_RES(48), .V_RES(640), .X_W(6), .Y_W(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_lcd_data(lcd_data), .i_lcd_wr(lcd_wr),
    .i_lcd_dc(lcd_dc), .i_lcd_rst(lcd_rst), .o_cmd_valid(cmd_valid), .o_cmd(cmd),
    .o_px_valid(px_valid), .o_px_data(px_data), .o_px_x(px_x), .o_px_y(px_y),
    .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dc;
    logic [7:0]  b;
    logic        e_cmd;
    logic [7:0]  e_cmdv;
    logic        e_px;
    logic [15:0] e_data;
    int          e_x;
    int          e_y;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic        cmd, px, err;
    logic [7:0]  cmd_v;
    logic [15:0] data;
    int          x, y, lat;
  } obs_t;

  int checks = 0;
  int failures = 0;
  int overlaps = 0;
  vec_t tbl[$];

  always @(negedge clk) if ($countones({cmd_valid, px_valid, err}) > 1) overlaps++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic dc, input logic [7:0] b, input logic ec,
                              input logic ep, input logic ee, input logic [15:0] d,
                              input int x, input int y);
    vec_t v;
    v.dc = dc; v.b = b; v.e_cmd = ec; v.e_cmdv = b; v.e_px = ep;
    v.e_err = ee; v.e_data = d; v.e_x = x; v.e_y = y;
    return v;
  endfunction

  function automatic vec_t cv(input logic [7:0] b);
    return mk(1'b0, b, 1'b1, 1'b0, 1'b0, 16'h0, 0, 0);
  endfunction
  function automatic vec_t dv(input logic [7:0] b);
    return mk(1'b1, b, 1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
  endfunction
  function automatic vec_t pv(input logic [7:0] b, input logic [15:0] d, input int x, input int y);
    return mk(1'b1, b, 1'b0, 1'b1, 1'b0, d, x, y);
  endfunction
  function automatic vec_t ev(input logic [7:0] b);
    return mk(1'b1, b, 1'b0, 1'b0, 1'b1, 16'h0, 0, 0);
  endfunction

  // One bus write: data/dc settle 2 cycles before the wr rise, wr falls 3 cycles after.
  // Pulses are observed over the 6 cycles following the rise.
  task automatic send_byte(input logic dc, input logic [7:0] b, output obs_t o);
    o.cmd = 1'b0; o.px = 1'b0; o.err = 1'b0; o.cmd_v = 8'h0;
    o.data = 16'h0; o.x = 0; o.y = 0; o.lat = 0;
    @(posedge clk); #1;
    lcd_dc = dc; lcd_data = b; lcd_wr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    lcd_wr = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (cmd_valid) begin o.cmd = 1'b1; o.cmd_v = cmd; if (o.lat == 0) o.lat = i; end
      if (px_valid) begin
        o.px = 1'b1; o.data = px_data; o.x = int'(px_x); o.y = int'(px_y);
        if (o.lat == 0) o.lat = i;
      end
      if (err) begin o.err = 1'b1; if (o.lat == 0) o.lat = i; end
      if (i == 3) lcd_wr = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    obs_t o;
    send_byte(v.dc, v.b, o);
    check({tag, " pulses{cmd,px,err}"}, 64'({o.cmd, o.px, o.err}), 64'({v.e_cmd, v.e_px, v.e_err}));
    if (v.e_cmd) check({tag, " o_cmd"}, 64'(o.cmd_v), 64'(v.e_cmdv));
    if (v.e_px) begin
      check({tag, " px_data"}, 64'(o.data), 64'(v.e_data));
      check({tag, " px_x"}, 64'(o.x), 64'(v.e_x));
      check({tag, " px_y"}, 64'(o.y), 64'(v.e_y));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, 64'({cmd_valid, cmd, px_valid, px_data, px_x, px_y, err}), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Reference model: the pixel address is derived from the pixel index inside the
  // window, not by stepping an address counter.
  int m_mode, m_xs, m_xe, m_ys, m_ye, m_nb;
  int m_par[$];
  logic [7:0] m_hi;

  task automatic model_reset();
    m_mode = 0; m_xs = 0; m_xe = 47; m_ys = 0; m_ye = 639; m_nb = 0;
    m_hi = 8'h0; m_par.delete();
  endtask

  task automatic model_step(input logic dc, input logic [7:0] b, output vec_t v);
    int s, e, lim, n, w, h;
    v = dv(b);
    v.dc = dc;
    if (!dc) begin
      v.e_cmd = 1'b1;
      m_par.delete();
      m_nb = 0;
      case (b)
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: m_mode = 3;
        8'h01: begin m_mode = 0; m_xs = 0; m_xe = 47; m_ys = 0; m_ye = 639; end
        default: m_mode = 4;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par.push_back(int'(b));
      if (m_par.size() == 4) begin
        s = m_par[0] * 256 + m_par[1];
        e = m_par[2] * 256 + m_par[3];
        lim = (m_mode == 1) ? 48 : 640;
        if (s <= e && e < lim) begin
          if (m_mode == 1) begin m_xs = s; m_xe = e; end
          else begin m_ys = s; m_ye = e; end
        end else begin
          v.e_err = 1'b1;
        end
        m_mode = 4;
        m_par.delete();
      end
    end else if (m_mode == 3) begin
      m_nb++;
      if (m_nb % 2 == 1) begin
        m_hi = b;
      end else begin
        n = m_nb / 2 - 1;
        w = m_xe - m_xs + 1;
        h = m_ye - m_ys + 1;
        v.e_px = 1'b1;
        v.e_data = {m_hi, b};
        v.e_x = m_xs + n % w;
        v.e_y = m_ys + (n / w) % h;
      end
    end
  endtask

  initial begin
    obs_t o;
    vec_t v;
    logic [7:0] b;
    logic dc;

    // Window write and wrap, invalid commits, aborts, SWRESET.
    tbl.push_back(cv(8'h2A)); tbl.push_back(dv(8'h00)); tbl.push_back(dv(8'h02));
    tbl.push_back(dv(8'h00)); tbl.push_back(dv(8'h03));
    tbl.push_back(cv(8'h2B)); tbl.push_back(dv(8'h00)); tbl.push_back(dv(8'h0A));
    tbl.push_back(dv(8'h00)); tbl.push_back(dv(8'h0B));
    tbl.push_back(cv(8'h2C));
    tbl.push_back(dv(8'hA1)); tbl.push_back(pv(8'hB2, 16'hA1B2, 2, 10));
    tbl.push_back(dv(8'hA3)); tbl.push_back(pv(8'hB4, 16'hA3B4, 3, 10));
    tbl.push_back(dv(8'hA5)); tbl.push_back(pv(8'hB6, 16'hA5B6, 2, 11));
    tbl.push_back(dv(8'hA7)); tbl.push_back(pv(8'hB8, 16'hA7B8, 3, 11));
    tbl.push_back(dv(8'hA9)); tbl.push_back(pv(8'hBA, 16'hA9BA, 2, 10));
    tbl.push_back(cv(8'h2A)); tbl.push_back(dv(8'h00)); tbl.push_back(dv(8'h05));
    tbl.push_back(dv(8'h00)); tbl.push_back(ev(8'h02));
    tbl.push_back(cv(8'h2C)); tbl.push_back(dv(8'h11)); tbl.push_back(pv(8'h22, 16'h1122, 2, 10));
    tbl.push_back(cv(8'h2A)); tbl.push_back(dv(8'h00)); tbl.push_back(dv(8'h00));
    tbl.push_back(dv(8'h00)); tbl.push_back(ev(8'h30));
    tbl.push_back(cv(8'h2B)); tbl.push_back(dv(8'h00)); tbl.push_back(dv(8'h00));
    tbl.push_back(dv(8'h02)); tbl.push_back(ev(8'h80)); tbl.push_back(dv(8'h55));
    tbl.push_back(cv(8'h2C)); tbl.push_back(dv(8'h12)); tbl.push_back(cv(8'h00));
    tbl.push_back(dv(8'h34));
    tbl.push_back(cv(8'h2B)); tbl.push_back(dv(8'h00)); tbl.push_back(dv(8'h00));
    tbl.push_back(cv(8'h2C)); tbl.push_back(dv(8'h01)); tbl.push_back(pv(8'h02, 16'h0102, 2, 10));
    tbl.push_back(cv(8'h01)); tbl.push_back(cv(8'h2C)); tbl.push_back(dv(8'h77));
    tbl.push_back(pv(8'h88, 16'h7788, 0, 0));

    lcd_data = 8'h00; lcd_wr = 1'b0; lcd_dc = 1'b0; lcd_rst = 1'b1; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("outputs during reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_outputs_zero("outputs after reset");

    // Latency of the first command, then the default full-screen window across a row.
    send_byte(1'b0, 8'h2C, o);
    check("latency wr rise to o_cmd_valid", 64'(o.lat), 64'd4);
    check("first cmd value", 64'({o.cmd, o.cmd_v}), 64'({1'b1, 8'h2C}));
    for (int n = 0; n < 49; n++) begin
      v = pv(8'(n) ^ 8'hFF, {8'(n), 8'(n) ^ 8'hFF}, n % 48, n / 48);
      run_vec(dv(8'(n)), $sformatf("default hi%0d", n));
      run_vec(v, $sformatf("default px%0d", n));
    end

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Panel reset in the middle of RAMWR with a pending hi byte.
    run_vec(cv(8'h2A), "prst caset");
    run_vec(dv(8'h00), "prst p0"); run_vec(dv(8'h02), "prst p1");
    run_vec(dv(8'h00), "prst p2"); run_vec(dv(8'h03), "prst p3");
    run_vec(cv(8'h2C), "prst ramwr");
    run_vec(dv(8'h5A), "prst hi");
    run_vec(pv(8'hA5, 16'h5AA5, 2, 0), "prst px");
    run_vec(dv(8'h66), "prst pending hi");
    @(posedge clk); #1 lcd_rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 lcd_rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_outputs_zero("outputs after panel reset");
    run_vec(dv(8'h77), "prst data0");
    run_vec(dv(8'h88), "prst data1");
    run_vec(cv(8'h2C), "prst ramwr2");
    run_vec(dv(8'h99), "prst hi2");
    run_vec(pv(8'hAA, 16'h99AA, 0, 0), "prst px2");
    run_vec(dv(8'hBB), "prst hi3");
    run_vec(pv(8'hCC, 16'hBBCC, 1, 0), "prst px3");

    // Randomized byte stream against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 300; i++) begin
      dc = ($urandom_range(0, 3) != 0);
      if (!dc) begin
        case ($urandom_range(0, 7))
          0, 1:    b = 8'h2A;
          2, 3:    b = 8'h2B;
          4, 5:    b = 8'h2C;
          6:       b = 8'h01;
          default: b = 8'($urandom);
        endcase
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3:    b = 8'h00;
          4, 5, 6, 7:    b = 8'($urandom_range(0, 50));
          8:             b = 8'($urandom_range(0, 2));
          default:       b = 8'($urandom);
        endcase
      end
      model_step(dc, b, v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    check("pulses never overlap", 64'(overlaps), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
